// File: rtl/tick_scheduler_if.sv
// Config request channel for tick_scheduler: a host selects a channel and
// offers a new divisor; the scheduler answers with cfg_ready.
interface tick_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_ch;
   logic [CNT_W-1:0] cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/tick_scheduler.sv
// Two-channel clock-enable generator. Each channel counts 0..div-1, pulses a
// tick on the last count and drives a registered square wave. Divisor changes
// arriving over the config port are parked until the channel's next period
// boundary, so no output period is ever cut short. A zero divisor stops the
// channel at that boundary; a non-zero write to a stopped channel restarts it.
module tick_scheduler #(
   parameter int CNT_W     = 16,
   parameter int DEF_DIV_A = 6,
   parameter int DEF_DIV_B = 12288
) (
   input  logic                 clk12Mhz,
   input  logic                 rst_n,
   tick_scheduler_if.slave      cfg,
   output logic                 tick_a,
   output logic                 tick_b,
   output logic                 clk_a,
   output logic                 clk_b,
   output logic                 run_a,
   output logic                 run_b,
   output logic                 pend_a,
   output logic                 pend_b
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   // Index 0 is channel A, index 1 is channel B throughout.
   state_t           state_q [2];
   state_t           state_d [2];
   logic [CNT_W-1:0] cnt_q   [2];
   logic [CNT_W-1:0] cnt_d   [2];
   logic [CNT_W-1:0] div_q   [2];
   logic [CNT_W-1:0] div_d   [2];
   logic [CNT_W-1:0] divp_q  [2];
   logic [CNT_W-1:0] divp_d  [2];

   logic [1:0] tick_q, tick_d;
   logic [1:0] sqw_q,  sqw_d;
   logic [1:0] run_q,  run_d;
   logic [1:0] pend_q, pend_d;

   logic [1:0] term;
   logic [1:0] acc;

   // A channel with a parked change refuses further requests until it applies it.
   always_comb begin
      cfg.cfg_ready = ~pend_q[cfg.cfg_ch];
   end

   // Terminal-cycle and per-channel accept strobes.
   always_comb begin
      term = '0;
      acc  = '0;
      for (int c = 0; c < 2; c++) begin
         term[c] = (state_q[c] != IDLE) && (cnt_q[c] == div_q[c] - CNT_W'(1));
         acc[c]  = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_ch) == c);
      end
   end

   // Next-state for both channel FSMs; outputs are derived from the next
   // state so that the registered tick/square wave line up with the count
   // they describe.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         div_d[c]   = div_q[c];
         divp_d[c]  = divp_q[c];
         case (state_q[c])
            IDLE: begin
               cnt_d[c] = '0;
               if (acc[c] && (cfg.cfg_div != '0)) begin
                  div_d[c]   = cfg.cfg_div;
                  state_d[c] = RUN;
               end
            end
            RUN: begin
               cnt_d[c] = term[c] ? '0 : cnt_q[c] + CNT_W'(1);
               // An accept in the terminal cycle is still parked for a full period.
               if (acc[c]) begin
                  divp_d[c]  = cfg.cfg_div;
                  state_d[c] = PEND;
               end
            end
            PEND: begin
               cnt_d[c] = term[c] ? '0 : cnt_q[c] + CNT_W'(1);
               if (term[c]) begin
                  if (divp_q[c] != '0) begin
                     div_d[c]   = divp_q[c];
                     state_d[c] = RUN;
                  end else begin
                     state_d[c] = IDLE;
                  end
               end
            end
            default: begin
               cnt_d[c]   = '0;
               state_d[c] = IDLE;
            end
         endcase
         tick_d[c] = (state_d[c] != IDLE) && (cnt_d[c] == div_d[c] - CNT_W'(1));
         sqw_d[c]  = (state_d[c] != IDLE) && (cnt_d[c] >= (div_d[c] >> 1));
         run_d[c]  = (state_d[c] != IDLE);
         pend_d[c] = (state_d[c] == PEND);
      end
   end

   // State and output registers; reset restarts both channels at their default rates.
   always_ff @(posedge clk12Mhz) begin
      if (!rst_n) begin
         state_q[0] <= RUN;
         state_q[1] <= RUN;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
         div_q[0]   <= CNT_W'(DEF_DIV_A);
         div_q[1]   <= CNT_W'(DEF_DIV_B);
         divp_q[0]  <= '0;
         divp_q[1]  <= '0;
         tick_q     <= '0;
         sqw_q      <= '0;
         run_q      <= 2'b11;
         pend_q     <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            div_q[c]   <= div_d[c];
            divp_q[c]  <= divp_d[c];
         end
         tick_q <= tick_d;
         sqw_q  <= sqw_d;
         run_q  <= run_d;
         pend_q <= pend_d;
      end
   end

   assign tick_a = tick_q[0];
   assign tick_b = tick_q[1];
   assign clk_a  = sqw_q[0];
   assign clk_b  = sqw_q[1];
   assign run_a  = run_q[0];
   assign run_b  = run_q[1];
   assign pend_a = pend_q[0];
   assign pend_b = pend_q[1];

endmodule
